// File: rtl/wormhole_sw_allocator_pkg.sv
// rtl/wormhole_sw_allocator_pkg.sv - shared router port constants, defaults and helpers
package wormhole_sw_allocator_pkg;

    localparam int LOCAL = 0;
    localparam int EAST  = 1;
    localparam int NORTH = 2;
    localparam int WEST  = 3;
    localparam int SOUTH = 4;

    localparam int PORT_NUM_DEF   = 5;
    localparam int CREDIT_NUM_DEF = 4;

    // Ceiling log2; used to size encoded port numbers and credit counters
    function automatic int log2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    typedef enum logic {
        OUT_IDLE   = 1'b0,
        OUT_LOCKED = 1'b1
    } out_state_e;

endpackage

// File: rtl/wormhole_sw_allocator_rr_arbiter.sv
// rtl/wormhole_sw_allocator_rr_arbiter.sv - round-robin arbiter, first request at or above ptr wins
module rr_arbiter #(
    parameter int N     = 5,
    parameter int PTR_W = 3
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt
);

    // Circular search starting at the pointer; only the first hit is granted
    always_comb begin
        logic found;
        int   idx;
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int off = 0; off < N; off++) begin
            idx = (int'(ptr) + off) % N;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wormhole_sw_allocator.sv
// rtl/wormhole_sw_allocator.sv - wormhole switch allocator with per-output lock and credits
module wormhole_sw_allocator
    import wormhole_sw_allocator_pkg::*;
#(
    parameter int PORT_NUM           = PORT_NUM_DEF,
    parameter int PORT_NUM_BCD_WIDTH = log2(PORT_NUM),
    parameter int CREDIT_NUM         = CREDIT_NUM_DEF
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [PORT_NUM-1:0]                   req_valid_in,
    input  logic [PORT_NUM*PORT_NUM_BCD_WIDTH-1:0] req_port_in,
    input  logic [PORT_NUM-1:0]                   hdr_flit_in,
    input  logic [PORT_NUM-1:0]                   tail_flit_in,
    input  logic [PORT_NUM-1:0]                   credit_in,
    output logic [PORT_NUM-1:0]                   grant_out,
    output logic [PORT_NUM*PORT_NUM-1:0]          xbar_sel_out,
    output logic [PORT_NUM-1:0]                   flit_wr_out,
    output logic [PORT_NUM-1:0]                   out_locked_out,
    output logic                                  port_err_out
);

    localparam int W            = PORT_NUM_BCD_WIDTH;
    localparam int CREDIT_WIDTH = log2(CREDIT_NUM + 1);
    localparam logic [W:0]              PORT_LIM = (W+1)'(PORT_NUM);
    localparam logic [CREDIT_WIDTH-1:0] CNT_MAX  = CREDIT_WIDTH'(CREDIT_NUM);

    out_state_e              state_q [PORT_NUM];
    out_state_e              state_d [PORT_NUM];
    logic [W-1:0]            owner_q [PORT_NUM];
    logic [W-1:0]            owner_d [PORT_NUM];
    logic [W-1:0]            rr_q    [PORT_NUM];
    logic [W-1:0]            rr_d    [PORT_NUM];
    logic [CREDIT_WIDTH-1:0] cnt_q   [PORT_NUM];
    logic [CREDIT_WIDTH-1:0] cnt_d   [PORT_NUM];
    logic                    port_err_q;
    logic                    port_err_d;

    logic [W-1:0]        port     [PORT_NUM];
    logic [PORT_NUM-1:0] cand     [PORT_NUM];
    logic [PORT_NUM-1:0] idle_gnt [PORT_NUM];
    logic [PORT_NUM-1:0] sel      [PORT_NUM];
    logic [PORT_NUM-1:0] port_ok;
    logic [PORT_NUM-1:0] owner_busy;

    // Split the packed port bus and flag requests naming a non-existent port
    always_comb begin
        for (int i = 0; i < PORT_NUM; i++) begin
            port[i]    = req_port_in[i*W +: W];
            port_ok[i] = ({1'b0, port[i]} < PORT_LIM);
        end
    end

    // An input already owning a locked output must not win a second output
    always_comb begin
        owner_busy = '0;
        for (int j = 0; j < PORT_NUM; j++) begin
            if (state_q[j] == OUT_LOCKED) owner_busy[owner_q[j]] = 1'b1;
        end
    end

    // Header candidates per idle output
    always_comb begin
        for (int j = 0; j < PORT_NUM; j++) begin
            for (int i = 0; i < PORT_NUM; i++) begin
                cand[j][i] = req_valid_in[i] & hdr_flit_in[i] & port_ok[i] &
                             ~owner_busy[i] & (port[i] == W'(j));
            end
        end
    end

    for (genvar j = 0; j < PORT_NUM; j++) begin : g_arb
        rr_arbiter #(
            .N     (PORT_NUM),
            .PTR_W (W)
        ) u_rr_arbiter (
            .req (cand[j]),
            .ptr (rr_q[j]),
            .gnt (idle_gnt[j])
        );
    end

    // Same-cycle crossbar decision: locked outputs follow their owner, idle ones the arbiter
    always_comb begin
        grant_out    = '0;
        flit_wr_out  = '0;
        xbar_sel_out = '0;
        for (int j = 0; j < PORT_NUM; j++) begin
            sel[j] = '0;
            if (!reset && cnt_q[j] != '0) begin
                if (state_q[j] == OUT_LOCKED) begin
                    if (req_valid_in[owner_q[j]] && port_ok[owner_q[j]]) sel[j][owner_q[j]] = 1'b1;
                end else begin
                    sel[j] = idle_gnt[j];
                end
            end
            xbar_sel_out[j*PORT_NUM +: PORT_NUM] = sel[j];
            flit_wr_out[j] = |sel[j];
            grant_out      = grant_out | sel[j];
        end
    end

    // Next lock state, owner, pointer and credit count per output
    always_comb begin
        logic [W-1:0] win;
        win        = '0;
        port_err_d = port_err_q | (|(req_valid_in & ~port_ok));
        for (int j = 0; j < PORT_NUM; j++) begin
            state_d[j] = state_q[j];
            owner_d[j] = owner_q[j];
            rr_d[j]    = rr_q[j];
            cnt_d[j]   = cnt_q[j];
            win        = '0;
            for (int i = 0; i < PORT_NUM; i++) begin
                if (sel[j][i]) win = W'(i);
            end
            if (flit_wr_out[j]) begin
                if (state_q[j] == OUT_IDLE) begin
                    rr_d[j] = (win == W'(PORT_NUM - 1)) ? '0 : win + W'(1);
                    if (!tail_flit_in[win]) begin
                        state_d[j] = OUT_LOCKED;
                        owner_d[j] = win;
                    end
                end else if (tail_flit_in[win]) begin
                    state_d[j] = OUT_IDLE;
                end
            end
            if (flit_wr_out[j] && !credit_in[j]) begin
                cnt_d[j] = cnt_q[j] - CREDIT_WIDTH'(1);
            end else if (credit_in[j] && !flit_wr_out[j] && cnt_q[j] != CNT_MAX) begin
                cnt_d[j] = cnt_q[j] + CREDIT_WIDTH'(1);
            end
        end
    end

    // State registers; reset drops any lock in progress and refills credits
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j < PORT_NUM; j++) begin
                state_q[j] <= OUT_IDLE;
                owner_q[j] <= '0;
                rr_q[j]    <= '0;
                cnt_q[j]   <= CNT_MAX;
            end
            port_err_q <= 1'b0;
        end else begin
            for (int j = 0; j < PORT_NUM; j++) begin
                state_q[j] <= state_d[j];
                owner_q[j] <= owner_d[j];
                rr_q[j]    <= rr_d[j];
                cnt_q[j]   <= cnt_d[j];
            end
            port_err_q <= port_err_d;
        end
    end

    // Registered status outputs
    always_comb begin
        for (int j = 0; j < PORT_NUM; j++) begin
            out_locked_out[j] = (state_q[j] == OUT_LOCKED);
        end
        port_err_out = port_err_q;
    end

endmodule

// File: tb/tb_wormhole_sw_allocator.sv
// tb/tb_wormhole_sw_allocator.sv - self-checking bench for wormhole_sw_allocator
module tb_wormhole_sw_allocator;

    localparam int N  = 5;
    localparam int W  = 3;
    localparam int CN = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid_in, hdr_flit_in, tail_flit_in, credit_in;
    logic [N*W-1:0] req_port_in;
    logic [N-1:0]   grant_out, flit_wr_out, out_locked_out;
    logic [N*N-1:0] xbar_sel_out;
    logic           port_err_out;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wormhole_sw_allocator dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid_in   (req_valid_in),
        .req_port_in    (req_port_in),
        .hdr_flit_in    (hdr_flit_in),
        .tail_flit_in   (tail_flit_in),
        .credit_in      (credit_in),
        .grant_out      (grant_out),
        .xbar_sel_out   (xbar_sel_out),
        .flit_wr_out    (flit_wr_out),
        .out_locked_out (out_locked_out),
        .port_err_out   (port_err_out)
    );

    typedef struct {
        logic [N-1:0]   v;
        logic [N*W-1:0] p;
        logic [N-1:0]   h;
        logic [N-1:0]   t;
        logic [N-1:0]   c;
        logic [N-1:0]   eg;
        logic [N-1:0]   ef;
        logic [N-1:0]   el;
    } vec_t;

    vec_t tbl [13];

    // Behavioural model state
    int m_cnt [N];
    int m_rr  [N];
    int m_own [N];
    bit m_lock[N];
    bit m_perr;
    int m_sel [N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [N*W-1:0] pk(input int p0, input int p1, input int p2, input int p3, input int p4);
        return {3'(p4), 3'(p3), 3'(p2), 3'(p1), 3'(p0)};
    endfunction

    task automatic drv(input logic [N-1:0] v, input logic [N*W-1:0] p, input logic [N-1:0] h,
                       input logic [N-1:0] t, input logic [N-1:0] c);
        req_valid_in = v;
        req_port_in  = p;
        hdr_flit_in  = h;
        tail_flit_in = t;
        credit_in    = c;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drv('0, '0, '0, '0, '0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic model_reset();
        for (int j = 0; j < N; j++) begin
            m_cnt[j] = CN; m_rr[j] = 0; m_own[j] = 0; m_lock[j] = 0;
        end
        m_perr = 0;
    endtask

    // Who drives each output this cycle, from the allocation rules
    task automatic model_decide(input bit rst);
        bit busy [N];
        int pi;
        for (int i = 0; i < N; i++) busy[i] = 0;
        for (int j = 0; j < N; j++) if (m_lock[j]) busy[m_own[j]] = 1;
        for (int j = 0; j < N; j++) begin
            m_sel[j] = -1;
            if (!rst && m_cnt[j] > 0) begin
                if (m_lock[j]) begin
                    pi = int'(req_port_in[m_own[j]*W +: W]);
                    if (req_valid_in[m_own[j]] && pi < N) m_sel[j] = m_own[j];
                end else begin
                    for (int k = 0; k < N; k++) begin
                        int i;
                        i  = (m_rr[j] + k) % N;
                        pi = int'(req_port_in[i*W +: W]);
                        if (m_sel[j] < 0 && req_valid_in[i] && hdr_flit_in[i] && pi == j && !busy[i])
                            m_sel[j] = i;
                    end
                end
            end
        end
    endtask

    task automatic model_update(input bit rst);
        if (rst) begin
            model_reset();
            return;
        end
        for (int i = 0; i < N; i++)
            if (req_valid_in[i] && int'(req_port_in[i*W +: W]) >= N) m_perr = 1;
        for (int j = 0; j < N; j++) begin
            bit wr;
            wr = (m_sel[j] >= 0);
            if (wr) begin
                if (!m_lock[j]) begin
                    m_rr[j] = (m_sel[j] + 1) % N;
                    if (!tail_flit_in[m_sel[j]]) begin
                        m_lock[j] = 1;
                        m_own[j]  = m_sel[j];
                    end
                end else if (tail_flit_in[m_sel[j]]) begin
                    m_lock[j] = 0;
                end
            end
            if (wr && !credit_in[j]) m_cnt[j]--;
            else if (credit_in[j] && !wr && m_cnt[j] < CN) m_cnt[j]++;
        end
    endtask

    initial begin
        int cnt;
        logic [N-1:0]   eg, ef, el;
        logic [N*N-1:0] ex;

        // Directed table, applied back to back from reset
        tbl[0]  = '{5'b00010, pk(0,4,0,0,0), 5'b00010, 5'b00010, 5'b00000, 5'b00010, 5'b10000, 5'b00000};
        tbl[1]  = '{5'b00000, pk(0,0,0,0,0), 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
        tbl[2]  = '{5'b01101, pk(1,0,1,1,0), 5'b01101, 5'b00000, 5'b00000, 5'b00001, 5'b00010, 5'b00000};
        tbl[3]  = '{5'b01101, pk(1,0,1,1,0), 5'b01100, 5'b00001, 5'b00000, 5'b00001, 5'b00010, 5'b00010};
        tbl[4]  = '{5'b01100, pk(0,0,1,1,0), 5'b01100, 5'b00100, 5'b00000, 5'b00100, 5'b00010, 5'b00000};
        tbl[5]  = '{5'b01000, pk(0,0,0,1,0), 5'b01000, 5'b01000, 5'b00000, 5'b01000, 5'b00010, 5'b00000};
        tbl[6]  = '{5'b01000, pk(0,0,0,1,0), 5'b01000, 5'b01000, 5'b00010, 5'b00000, 5'b00000, 5'b00000};
        tbl[7]  = '{5'b01000, pk(0,0,0,1,0), 5'b01000, 5'b01000, 5'b00000, 5'b01000, 5'b00010, 5'b00000};
        tbl[8]  = '{5'b11000, pk(0,0,0,0,0), 5'b11000, 5'b00000, 5'b00000, 5'b01000, 5'b00001, 5'b00000};
        tbl[9]  = '{5'b11000, pk(0,0,0,0,0), 5'b10000, 5'b00000, 5'b00000, 5'b01000, 5'b00001, 5'b00001};
        tbl[10] = '{5'b11000, pk(0,0,0,0,0), 5'b10000, 5'b00000, 5'b00000, 5'b01000, 5'b00001, 5'b00001};
        tbl[11] = '{5'b11000, pk(0,0,0,0,0), 5'b10000, 5'b01000, 5'b00001, 5'b01000, 5'b00001, 5'b00001};
        tbl[12] = '{5'b10000, pk(0,0,0,0,0), 5'b10000, 5'b10000, 5'b00000, 5'b10000, 5'b00001, 5'b00000};

        // Reset: decisions forced off while reset is high
        reset = 1'b1;
        drv('1, pk(0,0,0,0,0), '1, '0, '0);
        #2;
        chk("reset_grant", 32'(grant_out), 32'h0);
        chk("reset_xbar", 32'(xbar_sel_out), 32'h0);
        chk("reset_flit_wr", 32'(flit_wr_out), 32'h0);
        tick();
        tick();
        reset = 1'b0;
        drv('0, '0, '0, '0, '0);
        #2;
        chk("reset_locked", 32'(out_locked_out), 32'h0);
        chk("reset_port_err", 32'(port_err_out), 32'h0);
        tick();

        for (int k = 0; k < 13; k++) begin
            drv(tbl[k].v, tbl[k].p, tbl[k].h, tbl[k].t, tbl[k].c);
            ex = '0;
            for (int i = 0; i < N; i++)
                if (tbl[k].eg[i]) ex[int'(tbl[k].p[i*W +: W])*N + i] = 1'b1;
            #2;
            chk($sformatf("tbl%0d_grant", k), 32'(grant_out), 32'(tbl[k].eg));
            chk($sformatf("tbl%0d_flit_wr", k), 32'(flit_wr_out), 32'(tbl[k].ef));
            chk($sformatf("tbl%0d_locked", k), 32'(out_locked_out), 32'(tbl[k].el));
            chk($sformatf("tbl%0d_xbar", k), 32'(xbar_sel_out), 32'(ex));
            tick();
        end

        // Credit exhaustion: 4 grants, then one more per credit
        do_reset();
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            drv(5'b00001, pk(2,0,0,0,0), (c == 0) ? 5'b00001 : 5'b00000, '0, '0);
            #2; cnt += int'(grant_out[0]); tick();
        end
        chk("credit_stall_grants", 32'(cnt), 32'd4);
        chk("credit_stall_locked", 32'(out_locked_out), 32'b00100);
        drv(5'b00001, pk(2,0,0,0,0), '0, '0, 5'b00100);
        #2; chk("grant_at_zero_credit", 32'(grant_out), 32'h0); tick();
        cnt = 0;
        for (int c = 0; c < 4; c++) begin
            drv(5'b00001, pk(2,0,0,0,0), '0, '0, '0);
            #2; cnt += int'(grant_out[0]); tick();
        end
        chk("one_credit_one_grant", 32'(cnt), 32'd1);

        // Simultaneous credit and write at cnt=2 leaves cnt at 2
        for (int c = 0; c < 2; c++) begin
            drv('0, pk(2,0,0,0,0), '0, '0, 5'b00100); tick();
        end
        drv(5'b00001, pk(2,0,0,0,0), '0, '0, 5'b00100);
        #2; chk("both_cycle_flit_wr", 32'(flit_wr_out), 32'b00100); tick();
        cnt = 0;
        for (int c = 0; c < 5; c++) begin
            drv(5'b00001, pk(2,0,0,0,0), '0, '0, '0);
            #2; cnt += int'(grant_out[0]); tick();
        end
        chk("credit_and_write_hold", 32'(cnt), 32'd2);

        // Credit saturation at CREDIT_NUM
        do_reset();
        for (int c = 0; c < 3; c++) begin
            drv('0, '0, '0, '0, '1); tick();
        end
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            drv(5'b00010, pk(0,3,0,0,0), 5'b00010, 5'b00010, '0);
            #2; cnt += int'(grant_out[1]); tick();
        end
        chk("credit_saturate", 32'(cnt), 32'd4);

        // Reset mid-packet drops the lock and refills credits
        do_reset();
        drv(5'b00001, pk(2,0,0,0,0), 5'b00001, '0, '0); tick();
        drv(5'b00001, pk(2,0,0,0,0), '0, '0, '0);
        #2; chk("midpkt_locked", 32'(out_locked_out), 32'b00100); tick();
        reset = 1'b1;
        #2; chk("midpkt_reset_grant", 32'(grant_out), 32'h0); tick();
        reset = 1'b0;
        cnt = 0;
        for (int c = 0; c < 5; c++) begin
            drv(5'b10001, pk(2,0,0,0,2), 5'b10000, 5'b10000, '0);
            #2;
            if (c == 0) begin
                chk("after_reset_unlocked", 32'(out_locked_out), 32'h0);
                chk("after_reset_new_owner", 32'(grant_out), 32'b10000);
            end
            cnt += int'(grant_out[4]);
            tick();
        end
        chk("after_reset_credits", 32'(cnt), 32'd4);

        // Illegal port: never granted, sticky error until reset
        drv(5'b00010, pk(0,6,0,0,0), 5'b00010, 5'b00010, '0);
        #2;
        chk("bad_port_grant", 32'(grant_out), 32'h0);
        chk("bad_port_err_not_yet", 32'(port_err_out), 32'h0);
        tick();
        drv('0, '0, '0, '0, '0);
        #2; chk("bad_port_err_set", 32'(port_err_out), 32'h1);
        tick(); tick();
        #2; chk("bad_port_err_sticky", 32'(port_err_out), 32'h1);
        do_reset();
        #2; chk("bad_port_err_cleared", 32'(port_err_out), 32'h0);

        // Randomized traffic against the behavioural model
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            bit rst;
            logic [N*W-1:0] p;
            rst = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < N; i++)
                p[i*W +: W] = ($urandom_range(0, 29) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            reset = rst;
            drv(5'($urandom), p, 5'($urandom), 5'($urandom & $urandom), 5'($urandom & $urandom));
            model_decide(rst);
            eg = '0; ef = '0; ex = '0; el = '0;
            for (int j = 0; j < N; j++) begin
                el[j] = m_lock[j];
                if (m_sel[j] >= 0) begin
                    eg[m_sel[j]] = 1'b1;
                    ef[j] = 1'b1;
                    ex[j*N + m_sel[j]] = 1'b1;
                end
            end
            #2;
            chk("rnd_grant", 32'(grant_out), 32'(eg));
            chk("rnd_flit_wr", 32'(flit_wr_out), 32'(ef));
            chk("rnd_xbar", 32'(xbar_sel_out), 32'(ex));
            chk("rnd_locked", 32'(out_locked_out), 32'(el));
            chk("rnd_port_err", 32'(port_err_out), 32'(m_perr));
            tick();
            model_update(rst);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
